adder_operand_feeder: RTL and testbench

- Upstream feeder for the combinational adder stage: buffers (A, B) operand pairs from a valid/ready source in a small FIFO.
- Drives the FIFO head onto the adder's A/B inputs and captures the adder's X into a registered result stage with its own valid/ready handshake.
- Turns the purely combinational adder into a back-pressurable, in-order, one-result-per-cycle pipeline stage.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_operand_fifo.sv | 81 ++++++++
 rtl/adder_operand_feeder.sv | 136 +++++++++++++
 tb/tb_adder_operand_feeder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder operand feeder.
// The operand pair struct is the default storage type of the operand FIFO.
package adder_pkg;

   localparam int DATA_WIDTH = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } operand_pair_t;

   // Pointer width for a FIFO of the given depth (at least one bit).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/adder_operand_fifo.sv
// Small operand-pair FIFO feeding the adder.
// DEPTH must be a power of two so that the pointers wrap by natural overflow.
// The head is read combinationally from storage and reads as zero when empty;
// a push into an empty FIFO only becomes visible at the head on the next cycle.
module adder_operand_fifo
   import adder_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter type pair_t = operand_pair_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  logic  pop,
   input  pair_t wr_data,
   output pair_t head,
   output logic  full,
   output logic  empty
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   pair_t            mem_q [DEPTH];
   pair_t            mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // Head presentation: storage at the read pointer, zero when nothing is buffered.
   always_comb begin
      head = '0;
      if (!empty) begin
         head = mem_q[rd_ptr_q];
      end
   end

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset empties the FIFO immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/adder_operand_feeder.sv
// Adder operand feeder: buffers (A, B) pairs, presents the FIFO head to an
// external combinational adder and registers its sum into a valid/ready
// result stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and while valid is high without
// ready the data on that interface is held stable.
//
// Optional statistics counters are built when ADDER_OPERAND_FEEDER_STATS_EN is
// defined (ports stat_results and stat_overflows).
module adder_operand_feeder
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH = adder_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic [DATA_WIDTH-1:0] adder_a,
   output logic [DATA_WIDTH-1:0] adder_b,
   input  logic [DATA_WIDTH:0]   adder_x,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   out_x,
   output logic                  out_overflow
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
   ,
   output logic [31:0]           stat_results,
   output logic [31:0]           stat_overflows
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } pair_t;

   pair_t wr_pair;
   pair_t head_pair;
   logic  fifo_full;
   logic  fifo_empty;
   logic  push;
   logic  pop;
   logic  retire;

   logic                out_valid_q, out_valid_d;
   logic [DATA_WIDTH:0] out_x_q, out_x_d;

   assign wr_pair.a = in_a;
   assign wr_pair.b = in_b;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign pop      = !fifo_empty && (!out_valid_q || out_ready);
   assign retire   = out_valid_q && out_ready;

   adder_operand_fifo #(
      .DEPTH  (DEPTH),
      .pair_t (pair_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_pair),
      .head    (head_pair),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign adder_a      = head_pair.a;
   assign adder_b      = head_pair.b;
   assign out_valid    = out_valid_q;
   assign out_x        = out_x_q;
   assign out_overflow = out_x_q[DATA_WIDTH];

   // Result stage: load the adder output on pop, drop valid on a bare retire.
   always_comb begin
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_x_d     = adder_x;
      end else if (retire) begin
         out_valid_d = 1'b0;
      end
   end

   // Result registers; reset discards any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
      end
   end

`ifdef ADDER_OPERAND_FEEDER_STATS_EN
   logic [31:0] stat_results_q, stat_results_d;
   logic [31:0] stat_overflows_q, stat_overflows_d;

   assign stat_results   = stat_results_q;
   assign stat_overflows = stat_overflows_q;

   // Count retired results and retired overflowing results, wrapping at 2^32.
   always_comb begin
      stat_results_d   = stat_results_q;
      stat_overflows_d = stat_overflows_q;
      if (retire) begin
         stat_results_d = stat_results_q + 32'd1;
         if (out_x_q[DATA_WIDTH]) begin
            stat_overflows_d = stat_overflows_q + 32'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_results_q   <= '0;
         stat_overflows_q <= '0;
      end else begin
         stat_results_q   <= stat_results_d;
         stat_overflows_q <= stat_overflows_d;
      end
   end
`endif

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Bench for adder_operand_feeder (DATA_WIDTH=4, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge against a transaction-level model (queue of pending pairs
// plus one result slot) and an in-order scoreboard of expected sums.
module tb_adder_operand_feeder;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } tb_pair_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] adder_a;
  logic [DW-1:0] adder_b;
  logic [DW:0]   adder_x;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   out_x;
  logic          out_overflow;
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
  logic [31:0]   stat_results;
  logic [31:0]   stat_overflows;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  tb_pair_t      m_q[$];
  logic          m_res_v = 1'b0;
  logic [DW:0]   m_res_x = '0;
  logic [31:0]   m_stat_res = '0;
  logic [31:0]   m_stat_ovf = '0;
  logic [DW:0]   exp_q[$];

  // combinational adder the feeder drives
  assign adder_x = {1'b0, adder_a} + {1'b0, adder_b};

  adder_operand_feeder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .adder_x      (adder_x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_overflow (out_overflow)
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
    ,
    .stat_results   (stat_results),
    .stat_overflows (stat_overflows)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: compare on the falling edge, then advance across the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      tb_pair_t    p;
      logic [DW:0] e;
      logic        m_push;
      logic        m_pop;
      check_val("out_valid", 32'(out_valid), 32'(m_res_v));
      check_val("out_x", 32'(out_x), 32'(m_res_x));
      check_val("out_overflow", 32'(out_overflow), 32'(m_res_x[DW]));
      check_val("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      check_val("adder_a", 32'(adder_a), (m_q.size() != 0) ? 32'(m_q[0].a) : 32'd0);
      check_val("adder_b", 32'(adder_b), (m_q.size() != 0) ? 32'(m_q[0].b) : 32'd0);
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
      check_val("stat_results", stat_results, m_stat_res);
      check_val("stat_overflows", stat_overflows, m_stat_ovf);
`endif
      // scoreboard: the result leaving on the coming edge must be next in order
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_result", 32'(out_x), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_order", 32'(out_x), 32'(e));
        end
      end
      m_push = in_valid && (m_q.size() != DEPTH);
      m_pop  = (m_q.size() != 0) && (!m_res_v || out_ready);
      if (m_res_v && out_ready) begin
        m_stat_res = m_stat_res + 32'd1;
        if (m_res_x[DW]) m_stat_ovf = m_stat_ovf + 32'd1;
      end
      if (m_pop) begin
        p       = m_q.pop_front();
        m_res_v = 1'b1;
        m_res_x = {1'b0, p.a} + {1'b0, p.b};
      end else if (m_res_v && out_ready) begin
        m_res_v = 1'b0;
      end
      if (m_push) begin
        p.a = in_a;
        p.b = in_b;
        m_q.push_back(p);
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
      end
    end
  end

  // driver tasks: called and returning at rising edge + 1
  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int budget, output bit ok);
    bit acc;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    in_valid = 1'b0;
    if (!ok) check_val("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_x", 32'(out_x), 32'd0);
    check_val("rst_out_overflow", 32'(out_overflow), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_adder_a", 32'(adder_a), 32'd0);
    check_val("rst_adder_b", 32'(adder_b), 32'd0);
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
    check_val("rst_stat_results", stat_results, 32'd0);
    check_val("rst_stat_overflows", stat_overflows, 32'd0);
`endif
    m_q.delete();
    exp_q.delete();
    m_res_v    = 1'b0;
    m_res_x    = '0;
    m_stat_res = '0;
    m_stat_ovf = '0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    bit got6;
    int acc_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset asserted mid-cycle acts immediately
    do_async_reset();
    idle(2);

    // single pair: 2-cycle latency
    out_ready = 1'b1;
    push_pair(4'd3, 4'd5, 4, ok);
    @(negedge clk);
    check_val("single_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("single_valid", 32'(out_valid), 32'd1);
    check_val("single_x", 32'(out_x), 32'd8);
    check_val("single_ovf", 32'(out_overflow), 32'd0);
    @(posedge clk);
    #1;
    idle(2);

    // overflow
    push_pair(4'd15, 4'd1, 4, ok);
    @(negedge clk);
    @(negedge clk);
    check_val("ovf_x", 32'(out_x), 32'h10);
    check_val("ovf_flag", 32'(out_overflow), 32'd1);
    @(posedge clk);
    #1;
    idle(2);
`ifdef ADDER_OPERAND_FEEDER_STATS_EN
    check_val("stats_ovf_after", stat_overflows, 32'd1);
    check_val("stats_res_after", stat_results, 32'd2);
`endif

    // backpressure: FIFO plus result register hold 5 pairs
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 1; i <= 5; i++) begin
      push_pair(DW'(i), DW'(i), 4, ok);
      acc_cnt += int'(ok);
    end
    check_val("bp_accepted", 32'(acc_cnt), 32'd5);
    in_valid = 1'b1;
    in_a     = 4'd6;
    in_b     = 4'd6;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_full", 32'(in_ready), 32'd0);
      check_val("bp_hold_x", 32'(out_x), 32'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    got6      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_drain_valid", 32'(out_valid), 32'd1);
      check_val("bp_drain_x", 32'(out_x), 32'(2 * (k + 1)));
      if (in_ready && in_valid) got6 = 1'b1;
      @(posedge clk);
      #1;
      if (got6) in_valid = 1'b0;
    end
    check_val("bp_sixth_accepted", 32'(got6), 32'd1);
    idle(4);

    // streaming: one pair per cycle, never back-pressured
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a     = DW'($urandom_range(0, 15));
      in_b     = DW'($urandom_range(0, 15));
      @(negedge clk);
      check_val("stream_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    idle(4);

    // reset mid-operation discards buffered pairs and the pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_pair(DW'(i + 2), DW'(i + 1), 4, ok);
    do_async_reset();
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("post_rst_quiet", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    push_pair(4'd7, 4'd7, 4, ok);
    @(negedge clk);
    check_val("post_rst_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("post_rst_valid", 32'(out_valid), 32'd1);
    check_val("post_rst_x", 32'(out_x), 32'd14);
    @(posedge clk);
    #1;
    idle(2);

    // randomized traffic with random back-pressure
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = DW'($urandom_range(0, 15));
      in_b      = DW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
